// File: rtl/cc_gen.sv
// ---------------------------------------------------------------------------
// cc_gen
// Condition-code (NZP) generation for a five-stage LC-3 style pipeline.
// The block tracks the CC-writing instruction through the MEM and WB stages.
// It forwards the NZP value of a resolvable MEM-stage writer to the branch
// logic and holds the architectural NZP register.
//
// Ports
//   clk          : sole clock, all state changes on the rising edge
//   reset        : synchronous active-high reset, overrides stall and flush
//   stall        : holds the MEM and WB stage registers
//   flush        : squashes the EX instruction so it is not captured into MEM
//   ex_valid     : EX holds a real instruction
//   ex_load_cc   : EX instruction writes condition codes
//   ex_is_load   : CC source is memory read data rather than ex_result
//   ex_result    : ALU/LEA result from EX
//   mem_rdata    : data memory read data for the MEM-stage instruction
//   mem_resp     : mem_rdata is valid this cycle
//   cc           : architectural NZP register {n,z,p}
//   mem_nzp      : forwarded NZP of the MEM-stage CC writer, 000 if none
//   cc_busy      : a CC writer is in flight in MEM or WB
//   cc_updates   : wrapping count of architectural CC writes
// ---------------------------------------------------------------------------
module cc_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_load_cc,
    input  logic        ex_is_load,
    input  logic [15:0] ex_result,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic [2:0]  cc,
    output logic [2:0]  mem_nzp,
    output logic        cc_busy,
    output logic [15:0] cc_updates
);

    // MEM stage state
    logic        mem_v;
    logic        mem_ldcc;
    logic        mem_isload;
    logic [15:0] mem_result;

    // WB stage state
    logic        wb_v;
    logic        wb_ldcc;
    logic [2:0]  wb_nzp;

    logic        wb_writes_cc;

    // Exactly one of n, z, p is set for any 16-bit value.
    function automatic logic [2:0] nzp(input logic [15:0] d);
        nzp = {d[15], (d == 16'h0000), (!d[15] && (d != 16'h0000))};
    endfunction

    assign wb_writes_cc = wb_v && wb_ldcc;

    // MEM stage capture. flush only suppresses the valid bit, so a squashed
    // slot still carries harmless field values. During stall the slot holds,
    // which also makes flush ineffective while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_v      <= 1'b0;
            mem_ldcc   <= 1'b0;
            mem_isload <= 1'b0;
            mem_result <= 16'h0000;
        end else if (!stall) begin
            mem_v      <= ex_valid && !flush;
            mem_ldcc   <= ex_load_cc;
            mem_isload <= ex_is_load;
            mem_result <= ex_result;
        end
    end

    // WB stage capture. The NZP is resolved here so WB only needs three bits.
    // A load samples mem_rdata on the unstalled edge; the memory side keeps
    // the stall asserted until the read data is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_v    <= 1'b0;
            wb_ldcc <= 1'b0;
            wb_nzp  <= 3'b000;
        end else if (!stall) begin
            wb_v    <= mem_v;
            wb_ldcc <= mem_ldcc;
            wb_nzp  <= mem_isload ? nzp(mem_rdata) : nzp(mem_result);
        end
    end

    // Architectural CC write. Rewriting the same value while stalled is
    // harmless, but the counter only advances on the edge where WB releases
    // the instruction, so each writer is counted once.
    always_ff @(posedge clk) begin
        if (reset) begin
            cc         <= 3'b010;
            cc_updates <= 16'h0000;
        end else begin
            if (wb_writes_cc) begin
                cc <= wb_nzp;
            end
            if (wb_writes_cc && !stall) begin
                cc_updates <= cc_updates + 16'd1;
            end
        end
    end

    // Forwarding path. A load is only forwardable once its read data has
    // arrived. Until then the branch logic must see 000 and wait on cc_busy.
    always_comb begin
        mem_nzp = 3'b000;
        if (mem_v && mem_ldcc) begin
            if (!mem_isload) begin
                mem_nzp = nzp(mem_result);
            end else if (mem_resp) begin
                mem_nzp = nzp(mem_rdata);
            end
        end
    end

    assign cc_busy = (mem_v && mem_ldcc) || wb_writes_cc;

endmodule

// File: tb/tb_cc_gen.sv
// ---------------------------------------------------------------------------
// tb_cc_gen
// Self-checking bench for cc_gen. Directed scenarios are checked against
// hand-derived constants. A randomized run is checked against a reference
// model that treats the pipeline as two instruction slots and derives NZP
// from the signed value of the data.
// ---------------------------------------------------------------------------
module tb_cc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic        ex_load_cc;
    logic        ex_is_load;
    logic [15:0] ex_result;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [2:0]  cc;
    logic [2:0]  mem_nzp;
    logic        cc_busy;
    logic [15:0] cc_updates;

    int checks   = 0;
    int failures = 0;

    // Reference model: one instruction slot per stage plus architectural state
    logic        r_mv, r_mld, r_misl;
    logic [15:0] r_mres;
    logic        r_wv, r_wld;
    logic [2:0]  r_wnzp;
    logic [2:0]  r_cc;
    logic [15:0] r_cnt;

    cc_gen dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_load_cc (ex_load_cc),
        .ex_is_load (ex_is_load),
        .ex_result  (ex_result),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .cc         (cc),
        .mem_nzp    (mem_nzp),
        .cc_busy    (cc_busy),
        .cc_updates (cc_updates)
    );

    always #5 clk = ~clk;

    // Sign classification of the value as a two's complement number
    function automatic logic [2:0] ref_nzp(input logic [15:0] d);
        shortint s;
        s = d;
        if (s < 0)       return 3'b100;
        else if (s == 0) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic logic [2:0] ref_mem_nzp();
        if (r_mv && r_mld && (!r_misl || mem_resp))
            return ref_nzp(r_misl ? mem_rdata : r_mres);
        return 3'b000;
    endfunction

    function automatic logic ref_busy();
        return (r_mv && r_mld) || (r_wv && r_wld);
    endfunction

    // One clock edge. The model advances with the same inputs the DUT samples
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            r_mv = 1'b0; r_mld = 1'b0; r_misl = 1'b0; r_mres = 16'h0000;
            r_wv = 1'b0; r_wld = 1'b0; r_wnzp = 3'b000;
            r_cc = 3'b010; r_cnt = 16'h0000;
        end else begin
            if (r_wv && r_wld) begin
                r_cc = r_wnzp;
                if (!stall) r_cnt = r_cnt + 16'd1;
            end
            if (!stall) begin
                r_wv   = r_mv;
                r_wld  = r_mld;
                r_wnzp = ref_nzp(r_misl ? mem_rdata : r_mres);
                r_mv   = ex_valid && !flush;
                r_mld  = ex_load_cc;
                r_misl = ex_is_load;
                r_mres = ex_result;
            end
        end
        #1;
    endtask

    task automatic set_ex(input logic v, input logic ld, input logic isl,
                          input logic [15:0] res);
        ex_valid   = v;
        ex_load_cc = ld;
        ex_is_load = isl;
        ex_result  = res;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        mem_rdata = 16'h0000; mem_resp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL reset_cc: got %b expected %b", cc, 3'b010);
        end
        checks++;
        if (mem_nzp !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_mem_nzp: got %b expected %b", mem_nzp, 3'b000);
        end
        checks++;
        if (cc_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_busy: got %b expected %b", cc_busy, 1'b0);
        end
        checks++;
        if (cc_updates !== 16'h0000) begin
            failures++; $display("[TB] FAIL reset_count: got %h expected %h", cc_updates, 16'h0000);
        end
    endtask

    task automatic test_alu_path();
        set_ex(1'b1, 1'b1, 1'b0, 16'h8000);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (mem_nzp !== 3'b100) begin
            failures++; $display("[TB] FAIL alu_mem_nzp: got %b expected %b", mem_nzp, 3'b100);
        end
        checks++;
        if (cc_busy !== 1'b1) begin
            failures++; $display("[TB] FAIL alu_busy: got %b expected %b", cc_busy, 1'b1);
        end
        tick();
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL alu_cc_early: got %b expected %b", cc, 3'b010);
        end
        tick();
        checks++;
        if (cc !== 3'b100) begin
            failures++; $display("[TB] FAIL alu_cc: got %b expected %b", cc, 3'b100);
        end
        checks++;
        if (cc_updates !== 16'd1) begin
            failures++; $display("[TB] FAIL alu_count: got %0d expected %0d", cc_updates, 1);
        end
        checks++;
        if (cc_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL alu_busy_clear: got %b expected %b", cc_busy, 1'b0);
        end
    endtask

    task automatic test_load_path();
        set_ex(1'b1, 1'b1, 1'b1, 16'h4321);
        tick();
        // Unrelated EX contents while stalled must not disturb MEM
        stall = 1'b1; mem_resp = 1'b0; mem_rdata = 16'h7777;
        set_ex(1'b1, 1'b1, 1'b0, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_nzp !== 3'b000) begin
                failures++; $display("[TB] FAIL load_wait_nzp[%0d]: got %b expected %b", i, mem_nzp, 3'b000);
            end
            checks++;
            if (cc_busy !== 1'b1) begin
                failures++; $display("[TB] FAIL load_wait_busy[%0d]: got %b expected %b", i, cc_busy, 1'b1);
            end
            tick();
        end
        mem_resp = 1'b1; mem_rdata = 16'h0000; stall = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (mem_nzp !== 3'b010) begin
            failures++; $display("[TB] FAIL load_mem_nzp: got %b expected %b", mem_nzp, 3'b010);
        end
        tick();
        mem_resp = 1'b0; mem_rdata = 16'h0042;
        tick();
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL load_cc: got %b expected %b", cc, 3'b010);
        end
        tick();
        checks++;
        if (cc_updates !== 16'd2) begin
            failures++; $display("[TB] FAIL load_count: got %0d expected %0d", cc_updates, 2);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        set_ex(1'b1, 1'b1, 1'b0, 16'h0005);
        tick();
        flush = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        checks++;
        if (mem_nzp !== 3'b000) begin
            failures++; $display("[TB] FAIL flush_mem_nzp: got %b expected %b", mem_nzp, 3'b000);
        end
        checks++;
        if (cc_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_busy: got %b expected %b", cc_busy, 1'b0);
        end
        tick(); tick(); tick();
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL flush_cc: got %b expected %b", cc, 3'b010);
        end
        checks++;
        if (cc_updates !== 16'd2) begin
            failures++; $display("[TB] FAIL flush_count: got %0d expected %0d", cc_updates, 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        logic [2:0]  exp  [3];
        vals[0] = 16'h0001; vals[1] = 16'h0000; vals[2] = 16'hFFFF;
        exp[0]  = 3'b001;   exp[1]  = 3'b010;   exp[2]  = 3'b100;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_ex(1'b1, 1'b1, 1'b0, vals[i]);
            else       set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
            tick();
            if (i >= 2) begin
                checks++;
                if (cc !== exp[i-2]) begin
                    failures++; $display("[TB] FAIL b2b_cc[%0d]: got %b expected %b", i - 2, cc, exp[i-2]);
                end
            end
        end
        checks++;
        if (cc_updates !== 16'd5) begin
            failures++; $display("[TB] FAIL b2b_count: got %0d expected %0d", cc_updates, 5);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       ex_result = 16'h0000;
                1:       ex_result = 16'h8000 | 16'($urandom);
                default: ex_result = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       mem_rdata = 16'h0000;
                1:       mem_rdata = 16'h8000 | 16'($urandom);
                default: mem_rdata = 16'($urandom);
            endcase
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_load_cc = ($urandom_range(0, 2) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            mem_resp   = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (mem_nzp !== ref_mem_nzp()) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_mem_nzp[%0d]: got %b expected %b", i, mem_nzp, ref_mem_nzp());
            end
            checks++;
            if (cc_busy !== ref_busy()) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_busy[%0d]: got %b expected %b", i, cc_busy, ref_busy());
            end
            checks++;
            if (cc !== r_cc) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_cc[%0d]: got %b expected %b", i, cc, r_cc);
            end
            checks++;
            if (cc_updates !== r_cnt) begin
                failures++; errs++;
                if (errs < 10) $display("[TB] FAIL rand_count[%0d]: got %h expected %h", i, cc_updates, r_cnt);
            end
            tick();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        reset = 1'b1;
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 16'hFFFF);
        n = 0;
        while (r_cnt != 16'hFFFF && n < 70000) begin
            tick();
            n++;
        end
        checks++;
        if (cc_updates !== 16'hFFFF) begin
            failures++; $display("[TB] FAIL wrap_full: got %h expected %h", cc_updates, 16'hFFFF);
        end
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (cc_updates !== 16'h0000) begin
            failures++; $display("[TB] FAIL wrap_zero: got %h expected %h", cc_updates, 16'h0000);
        end
        checks++;
        if (cc !== 3'b100) begin
            failures++; $display("[TB] FAIL wrap_cc: got %b expected %b", cc, 3'b100);
        end
    endtask

    task automatic test_reset_midflight();
        set_ex(1'b1, 1'b1, 1'b0, 16'h0001);
        tick();
        set_ex(1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (cc_busy !== 1'b0) begin
            failures++; $display("[TB] FAIL midrst_busy: got %b expected %b", cc_busy, 1'b0);
        end
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL midrst_cc: got %b expected %b", cc, 3'b010);
        end
        tick(); tick();
        checks++;
        if (cc !== 3'b010) begin
            failures++; $display("[TB] FAIL midrst_cc_later: got %b expected %b", cc, 3'b010);
        end
        checks++;
        if (cc_updates !== 16'h0000) begin
            failures++; $display("[TB] FAIL midrst_count: got %h expected %h", cc_updates, 16'h0000);
        end
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_load_path();
        test_flush();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
